// File: rtl/macro_arbiter_rr_onehot.sv
// Round-robin arbiter with a registered one-hot grant and a ready/valid
// handshake toward the consumer.
// The priority pointer only moves on an accepted grant. It then points just
// past the index that was served, so a requester that keeps requesting is
// served again within INPUT_WIDTH handshakes.
// On a handshake the next winner is picked in the same cycle, so a busy
// arbiter issues grants back-to-back with no idle cycle between them.

module macro_arbiter_rr_onehot #(
    parameter int INPUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [INPUT_WIDTH-1:0] req,
    input  logic                   flush,
    input  logic                   grant_ready,
    output logic [INPUT_WIDTH-1:0] grant,
    output logic                   grant_valid
);

    localparam int PW = $clog2(INPUT_WIDTH);
    localparam logic [PW-1:0]          PTR_ONE     = PW'(1'b1);
    localparam logic [INPUT_WIDTH-1:0] ONE_HOT_LSB = INPUT_WIDTH'(1'b1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [PW-1:0]          ptr_r;
    logic [PW-1:0]          grant_idx_r;
    logic [INPUT_WIDTH-1:0] grant_r;
    logic                   grant_valid_r;

    logic [PW-1:0]          base_s;
    logic [PW:0]            pick_s;
    logic                   win_found_s;
    logic [PW-1:0]          win_idx_s;

    // Return {found, index}: the first set bit of r, scanning upward from
    // base. The scan wraps naturally because the index is PW bits wide.
    function automatic logic [PW:0] rr_pick(
        input logic [INPUT_WIDTH-1:0] r,
        input logic [PW-1:0]          base
    );
        logic [PW:0]   res;
        logic [PW-1:0] cand;
        res = {1'b0, {PW{1'b0}}};
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            cand = base + PW'(i);
            if (!res[PW] && r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Choose where the scan starts. While granting, a handshake moves the
    // pointer to one past the served index, so the scan starts there.
    always_comb begin
        base_s = ptr_r;
        if (state_r == GRANT) begin
            base_s = grant_idx_r + PTR_ONE;
        end else begin
            base_s = ptr_r;
        end
        pick_s      = rr_pick(req, base_s);
        win_found_s = pick_s[PW];
        win_idx_s   = pick_s[PW-1:0];
    end

    // Arbiter state machine. Flush takes priority over a handshake and over
    // new requests, and it leaves the pointer where it is.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            ptr_r         <= {PW{1'b0}};
            grant_idx_r   <= {PW{1'b0}};
            grant_r       <= {INPUT_WIDTH{1'b0}};
            grant_valid_r <= 1'b0;
        end else if (flush) begin
            state_r       <= IDLE;
            grant_r       <= {INPUT_WIDTH{1'b0}};
            grant_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r       <= GRANT;
                        grant_idx_r   <= win_idx_s;
                        grant_r       <= ONE_HOT_LSB << win_idx_s;
                        grant_valid_r <= 1'b1;
                    end else begin
                        state_r       <= IDLE;
                        grant_r       <= {INPUT_WIDTH{1'b0}};
                        grant_valid_r <= 1'b0;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
                        ptr_r <= base_s;
                        if (win_found_s) begin
                            state_r       <= GRANT;
                            grant_idx_r   <= win_idx_s;
                            grant_r       <= ONE_HOT_LSB << win_idx_s;
                            grant_valid_r <= 1'b1;
                        end else begin
                            state_r       <= IDLE;
                            grant_r       <= {INPUT_WIDTH{1'b0}};
                            grant_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r       <= GRANT;
                        grant_r       <= grant_r;
                        grant_valid_r <= grant_valid_r;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    grant_r       <= {INPUT_WIDTH{1'b0}};
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;

endmodule

// File: tb/tb_macro_arbiter_rr_onehot.sv
// Bench for macro_arbiter_rr_onehot (INPUT_WIDTH=16). It runs directed
// scenarios with literal expectations, then randomized traffic compared
// every cycle against a behavioural round-robin model.

module tb_macro_arbiter_rr_onehot;

    localparam int W = 16;

    logic         clk;
    logic         resetn;
    logic [W-1:0] req;
    logic         flush;
    logic         grant_ready;
    logic [W-1:0] grant;
    logic         grant_valid;

    int checks;
    int failures;
    bit started;

    // Reference model: which requester holds the grant, and where the
    // search starts next.
    bit m_valid;
    int m_idx;
    int m_ptr;

    macro_arbiter_rr_onehot #(.INPUT_WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .flush       (flush),
        .grant_ready (grant_ready),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return the first requester at or after start, going round the ring,
    // or -1 if nobody is requesting.
    function automatic int first_req(input logic [W-1:0] r, input int start);
        for (int k = 0; k < W; k++) begin
            if (r[(start + k) % W]) return (start + k) % W;
        end
        return -1;
    endfunction

    // Behavioural model of the arbiter, advanced on each clock edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_ptr   <= 0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!m_valid) begin
            if (first_req(req, m_ptr) >= 0) begin
                m_valid <= 1'b1;
                m_idx   <= first_req(req, m_ptr);
            end
        end else if (grant_ready) begin
            m_ptr <= (m_idx + 1) % W;
            if (first_req(req, (m_idx + 1) % W) >= 0) begin
                m_valid <= 1'b1;
                m_idx   <= first_req(req, (m_idx + 1) % W);
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Each cycle, compare the DUT outputs with the model and check the
    // one-hot property.
    always @(negedge clk) begin
        if (started && resetn) begin
            logic [W-1:0] exp_g;
            exp_g = m_valid ? (W'(1) << m_idx) : {W{1'b0}};
            checks = checks + 1;
            if (grant !== exp_g || grant_valid !== m_valid) begin
                failures = failures + 1;
                $display("FAIL model_cmp t=%0t: got grant=%h valid=%b, expected grant=%h valid=%b",
                         $time, grant, grant_valid, exp_g, m_valid);
            end
            checks = checks + 1;
            if ($countones(grant) > 1 || grant_valid !== (grant != {W{1'b0}})) begin
                failures = failures + 1;
                $display("FAIL onehot t=%0t: got grant=%h valid=%b, required at most one bit and valid==(grant!=0)",
                         $time, grant, grant_valid);
            end
        end
    end

    // Apply one cycle of inputs and return at the following falling edge.
    task automatic step(input logic [W-1:0] r, input logic f, input logic gr);
        req         = r;
        flush       = f;
        grant_ready = gr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] eg, input logic ev);
        checks = checks + 1;
        if (grant !== eg || grant_valid !== ev) begin
            failures = failures + 1;
            $display("FAIL %s: got grant=%h valid=%b, expected grant=%h valid=%b",
                     name, grant, grant_valid, eg, ev);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        started     = 1'b0;
        resetn      = 1'b0;
        req         = {W{1'b0}};
        flush       = 1'b0;
        grant_ready = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset_state", 16'h0000, 1'b0);
        resetn  = 1'b1;
        started = 1'b1;

        // Scenario 1: no requests
        for (int i = 0; i < 3; i++) begin
            step(16'h0000, 1'b0, 1'b0);
            expect_out("s1_idle", 16'h0000, 1'b0);
        end

        // Scenario 2: back-to-back alternation with wrap
        step(16'h8001, 1'b0, 1'b1); expect_out("s2_g0", 16'h0001, 1'b1);
        step(16'h8001, 1'b0, 1'b1); expect_out("s2_g1", 16'h8000, 1'b1);
        step(16'h8001, 1'b0, 1'b1); expect_out("s2_g2", 16'h0001, 1'b1);
        step(16'h0000, 1'b0, 1'b1); expect_out("s2_idle", 16'h0000, 1'b0);

        // Scenario 3: hold while not ready, even after the request drops (ptr=1)
        step(16'h0010, 1'b0, 1'b0); expect_out("s3_grant", 16'h0010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(16'h0000, 1'b0, 1'b0);
            expect_out("s3_hold", 16'h0010, 1'b1);
        end
        step(16'h0000, 1'b0, 1'b1); expect_out("s3_release", 16'h0000, 1'b0);

        // Scenario 4: grant 14, so ptr becomes 15, then serve 15 and wrap to 14
        step(16'h4000, 1'b0, 1'b0); expect_out("s4_g14", 16'h4000, 1'b1);
        step(16'h0000, 1'b0, 1'b1); expect_out("s4_idle", 16'h0000, 1'b0);
        step(16'hC000, 1'b0, 1'b0); expect_out("s4_g15", 16'h8000, 1'b1);
        step(16'hC000, 1'b0, 1'b1); expect_out("s4_wrap", 16'h4000, 1'b1);
        step(16'h0000, 1'b0, 1'b1); expect_out("s4_end", 16'h0000, 1'b0);

        // Scenario 5: flush beats ready and leaves ptr at 15, so index 2 wins over 3
        step(16'h0004, 1'b0, 1'b0); expect_out("s5_grant", 16'h0004, 1'b1);
        step(16'h0004, 1'b1, 1'b1); expect_out("s5_flush", 16'h0000, 1'b0);
        step(16'h000C, 1'b0, 1'b0); expect_out("s5_regrant", 16'h0004, 1'b1);
        step(16'h0000, 1'b1, 1'b0); expect_out("s5_flush2", 16'h0000, 1'b0);

        // Scenario 6: asynchronous reset between clock edges
        step(16'hFFFF, 1'b0, 1'b0); expect_out("s6_pre", 16'h8000, 1'b1);
        #2 resetn = 1'b0;
        #1 expect_out("s6_async", 16'h0000, 1'b0);
        #1 resetn = 1'b1;
        @(negedge clk);
        step(16'hFFFF, 1'b0, 1'b0); expect_out("s6_first", 16'h0001, 1'b1);

        // Randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] r;
            r = W'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & W'($urandom);
            if ($urandom_range(0, 7) == 0) r = {W{1'b0}};
            step(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
